regfile_2r1w: RTL and testbench

Parametrised successor to the single-register block: a DEPTH-entry register file with one write port and two independent registered read ports. It adds per-port enables, write-to-read bypass, an optional hard-wired zero entry and read-valid strobes. It sits between the datapath control and the ALU operand muxes of the team's processor lab designs.

---
 rtl/regfile_2r1w.sv | 65 ++++++
 tb/tb_regfile_2r1w.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH-entry register file, one write port, two registered read ports with write-first bypass
// Optional hard-wired zero at entry 0 masks both the stored value and the bypass path.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_port_1,
    input  logic                  read_enable_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_port_1,
    output logic                  read_valid_1,
    input  logic                  read_enable_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_port_2,
    output logic                  read_valid_2
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] read_port_1_q, read_port_1_d, read_port_2_q, read_port_2_d;
    logic                  read_valid_1_q, read_valid_1_d, read_valid_2_q, read_valid_2_d;
    logic [DATA_WIDTH-1:0] sel_1, sel_2;
    logic                  write_ok;

    always_comb begin
        write_ok = write_enable && !(ZERO_REG && write_addr == '0);
        mem_d = mem_q;
        if (write_ok) mem_d[write_addr] = write_port_1;
        // Zero entry wins over bypass so a dropped write can never leak out
        sel_1 = (ZERO_REG && read_addr_1 == '0) ? '0 :
                (write_enable && write_addr == read_addr_1) ? write_port_1 : mem_q[read_addr_1];
        sel_2 = (ZERO_REG && read_addr_2 == '0) ? '0 :
                (write_enable && write_addr == read_addr_2) ? write_port_1 : mem_q[read_addr_2];
        read_port_1_d  = read_enable_1 ? sel_1 : read_port_1_q;
        read_port_2_d  = read_enable_2 ? sel_2 : read_port_2_q;
        read_valid_1_d = read_enable_1;
        read_valid_2_d = read_enable_2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q          <= '{default: '0};
            read_port_1_q  <= '0;
            read_port_2_q  <= '0;
            read_valid_1_q <= 1'b0;
            read_valid_2_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            read_port_1_q  <= read_port_1_d;
            read_port_2_q  <= read_port_2_d;
            read_valid_1_q <= read_valid_1_d;
            read_valid_2_q <= read_valid_2_d;
        end
    end

    assign read_port_1  = read_port_1_q;
    assign read_port_2  = read_port_2_q;
    assign read_valid_1 = read_valid_1_q;
    assign read_valid_2 = read_valid_2_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: scoreboard bench driving a plain and a ZERO_REG instance with identical stimulus
module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, re1 = 1'b0, re2 = 1'b0;
    logic [2:0]  wa = '0, ra1 = '0, ra2 = '0;
    logic [31:0] wd = '0;
    logic [31:0] rp [4];
    logic        rv [4];
    logic [31:0] q [4][$];
    logic [31:0] hold [4];
    logic [31:0] mem [2][8];
    int          pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.ZERO_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .write_enable(we), .write_addr(wa), .write_port_1(wd),
        .read_enable_1(re1), .read_addr_1(ra1), .read_port_1(rp[0]), .read_valid_1(rv[0]),
        .read_enable_2(re2), .read_addr_2(ra2), .read_port_2(rp[1]), .read_valid_2(rv[1])
    );

    regfile_2r1w #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .write_enable(we), .write_addr(wa), .write_port_1(wd),
        .read_enable_1(re1), .read_addr_1(ra1), .read_port_1(rp[2]), .read_valid_1(rv[2]),
        .read_enable_2(re2), .read_addr_2(ra2), .read_port_2(rp[3]), .read_valid_2(rv[3])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Reference: what a read of address a returns this edge, given the write on the same edge
    function automatic logic [31:0] expect_rd(input int z, input logic [2:0] a);
        if (z == 1 && a == 3'd0) return 32'h0;
        if (we && wa == a) return wd;
        return mem[z][a];
    endfunction

    task automatic cyc(input bit w, input bit [2:0] wadr, input bit [31:0] wdat,
                       input bit r1, input bit [2:0] a1, input bit r2, input bit [2:0] a2);
        @(negedge clk);
        #1;
        we = w; wa = wadr; wd = wdat; re1 = r1; ra1 = a1; re2 = r2; ra2 = a2;
        for (int z = 0; z < 2; z++) begin
            if (r1) q[2*z].push_back(expect_rd(z, a1));
            if (r2) q[2*z+1].push_back(expect_rd(z, a2));
        end
        if (w) begin
            mem[0][wadr] = wdat;
            if (wadr != 3'd0) mem[1][wadr] = wdat;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst_data%0d", i), rp[i], 32'h0);
            chk($sformatf("async_rst_valid%0d", i), {31'h0, rv[i]}, 32'h0);
        end
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 8; a++) mem[z][a] = 32'h0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per valid pulse; between pulses the data must hold
    always @(negedge clk) begin
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                q[i].delete();
                hold[i] = 32'h0;
            end else if (rv[i]) begin
                if (q[i].size() == 0) chk($sformatf("spurious_valid_i%0d_p%0d", i/2, i%2+1), 32'd1, 32'd0);
                else begin
                    e = q[i].pop_front();
                    chk($sformatf("read_i%0d_p%0d", i/2, i%2+1), rp[i], e);
                    hold[i] = e;
                end
            end else chk($sformatf("hold_i%0d_p%0d", i/2, i%2+1), rp[i], hold[i]);
        end
    end

    initial begin
        do_reset();
        for (int a = 0; a < 8; a++) cyc(0, 0, 0, 1, 3'(a), 1, 3'(7 - a));
        idle();
        cyc(1, 3, 32'hABCDE, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0);
        idle(); idle();
        cyc(1, 5, 32'h11111, 0, 0, 0, 0);
        cyc(1, 5, 32'h12345, 1, 5, 1, 5);
        cyc(0, 0, 0, 1, 5, 1, 5);
        cyc(1, 1, 32'hA, 0, 0, 0, 0);
        cyc(1, 2, 32'hB, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(1, 7, 32'hFFFF_FFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 7, 1, 7);
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        cyc(0, 0, 0, 1, 6, 1, 6);
        idle();
        do_reset();
        for (int a = 0; a < 8; a++) cyc(0, 0, 0, 1, 3'(a), 1, 3'(a));
        cyc(1, 4, 32'h55, 1, 4, 1, 4);
        #1;
        do_reset();
        idle();
        cyc(0, 0, 0, 1, 4, 1, 4);
        idle(); idle();
        for (int i = 0; i < 4; i++) chk($sformatf("drain%0d", i), 32'(q[i].size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
